rot_undo_seq: RTL and testbench

//   Multi-cycle de-rotator: takes a WIDTH-bit word that was rotated left or right by a known amount and

---
 rtl/rot_undo_seq_pkg.sv | 15 +
 rtl/rot_undo_seq_if.sv | 28 ++
 rtl/rot_undo_seq_step.sv | 28 ++
 rtl/rot_undo_seq.sv | 105 ++++++++++
 tb/tb_rot_undo_seq.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/rot_undo_seq_pkg.sv
// rot_pkg: shared state encoding and direction constants for rot_undo_seq.
// No ports; imported by the interface, the step rotator and the top.
package rot_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROT  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Direction the encoder applied; the engine rotates the other way.
  localparam logic DIR_WAS_LEFT  = 1'b0;
  localparam logic DIR_WAS_RIGHT = 1'b1;

endpackage

// File: rtl/rot_undo_seq_if.sv
// rot_undo_seq_if: producer/consumer handshakes for the de-rotator.
// slave = engine side; master = producer+consumer side.
interface rot_undo_seq_if #(
  parameter int WIDTH = 4,
  parameter int AW    = $clog2(WIDTH)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AW-1:0]    in_amt;
  logic             in_dir;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;

  modport slave (
    input  in_valid, in_data, in_amt, in_dir,
    input  out_ready,
    output in_ready, out_valid, out_data, busy
  );

  modport master (
    output in_valid, in_data, in_amt, in_dir,
    output out_ready,
    input  in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/rot_undo_seq_step.sv
// rot_step: combinational rotate by 1 or 2 in the undo direction.
// Ports: i_word, i_dir (encoder dir), i_by2 (2-step), o_word.
module rot_step
  import rot_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_word,
  input  logic             i_dir,
  input  logic             i_by2,
  output logic [WIDTH-1:0] o_word
);

  logic [2*WIDTH-1:0] w_dbl;
  logic [2*WIDTH-1:0] w_r;
  logic [2*WIDTH-1:0] w_l;

  // Doubling the word turns a rotate into a plain shift,
  // which stays legal even for WIDTH=2.
  assign w_dbl = {i_word, i_word};
  assign w_r   = i_by2 ? (w_dbl >> 2) : (w_dbl >> 1);
  assign w_l   = i_by2 ? (w_dbl << 2) : (w_dbl << 1);

  assign o_word = (i_dir == DIR_WAS_LEFT)
                ? w_r[WIDTH-1:0]
                : w_l[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/rot_undo_seq.sv
// rot_undo_seq: multi-cycle de-rotator, one word in flight.
// Ports: clk, rst_n (async low), io (rot_undo_seq_if.slave).
// Build option: define FAST2_EN to step by 2 while >=2 remain.
module rot_undo_seq
  import rot_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int AW    = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  rot_undo_seq_if.slave io
);

  localparam logic [AW-1:0] ONE = AW'(1);

  state_t           r_state;
  logic [WIDTH-1:0] r_work;
  logic [AW-1:0]    r_rem;
  logic             r_dir;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;
  logic [WIDTH-1:0] r_out_data;

  logic             w_by2;
  logic [AW-1:0]    w_dec;
  logic [WIDTH-1:0] w_rot;

`ifdef FAST2_EN
  assign w_by2 = (r_rem > ONE);
`else
  assign w_by2 = 1'b0;
`endif

  assign w_dec = w_by2 ? (ONE + ONE) : ONE;

  rot_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_word (r_work),
    .i_dir  (r_dir),
    .i_by2  (w_by2),
    .o_word (w_rot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_work      <= '0;
      r_rem       <= '0;
      r_dir       <= DIR_WAS_LEFT;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_out_data  <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (io.in_valid) begin
            r_work     <= io.in_data;
            r_rem      <= io.in_amt;
            r_dir      <= io.in_dir;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            if (io.in_amt == '0) begin
              r_state     <= DONE;
              r_out_valid <= 1'b1;
              r_out_data  <= io.in_data;
            end else begin
              r_state <= ROT;
            end
          end
        end
        ROT: begin
          r_work <= w_rot;
          r_rem  <= r_rem - w_dec;
          // Last step: publish the rotated word directly.
          if (r_rem == w_dec) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_out_data  <= w_rot;
          end
        end
        DONE: begin
          if (io.out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign io.in_ready  = r_in_ready;
  assign io.out_valid = r_out_valid;
  assign io.out_data  = r_out_data;
  assign io.busy      = r_busy;

endmodule

// File: tb/tb_rot_undo_seq.sv
// tb_rot_undo_seq: randomized self-checking bench for rot_undo_seq.
// Reference model restores words with plain integer arithmetic.
module tb_rot_undo_seq;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  rot_undo_seq_if #(.WIDTH(4)) bus ();

  rot_undo_seq #(
    .WIDTH (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int rotl(input int d, input int a);
    return ((d << a) | (d >> (4 - a))) & 15;
  endfunction

  function automatic int rotr(input int d, input int a);
    return ((d >> a) | (d << (4 - a))) & 15;
  endfunction

  // dir 0: word was rotated left, so restore by rotating right.
  function automatic logic [3:0] restore(input int d, input int a,
                                         input bit dir);
    int r;
    r = dir ? rotl(d, a) : rotr(d, a);
    return r[3:0];
  endfunction

  function automatic int exp_lat(input int a);
`ifdef FAST2_EN
    return (a + 1) / 2 + 1;
`else
    return a + 1;
`endif
  endfunction

  task automatic xfer(input logic [3:0] d, input logic [1:0] a,
                      input bit dir, input int hold);
    logic [3:0] exp;
    int lat;
    exp = restore(int'(d), int'(a), dir);
    @(negedge clk);
    n_chk++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_ready got=%b want=1", bus.in_ready);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_amt   = a;
    bus.in_dir   = dir;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = 'x;
    bus.in_amt   = 'x;
    bus.in_dir   = 1'bx;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    n_chk++;
    if (lat != exp_lat(int'(a))) begin
      n_fail++;
      $display("FAIL latency d=%h a=%0d got=%0d want=%0d",
               d, a, lat, exp_lat(int'(a)));
    end
    n_chk++;
    if (bus.out_data !== exp) begin
      n_fail++;
      $display("FAIL data d=%h a=%0d dir=%0d got=%h want=%h",
               d, a, dir, bus.out_data, exp);
    end
    n_chk++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL done_flags busy=%b in_ready=%b want 1/0",
               bus.busy, bus.in_ready);
    end
    // Backpressure: a competing word is offered and must be ignored.
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = ~d;
      bus.in_amt   = 2'd1;
      bus.in_dir   = ~dir;
      @(posedge clk); #1;
      n_chk++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp ||
          bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold v=%b d=%h rdy=%b want 1/%h/0",
                 bus.out_valid, bus.out_data, bus.in_ready, exp);
      end
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.in_data   = 'x;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    n_chk++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL release v=%b busy=%b rdy=%b want 0/0/1",
               bus.out_valid, bus.busy, bus.in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 4'($urandom);
    bus.in_amt    = 2'($urandom);
    bus.in_dir    = 1'($urandom);
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
        bus.busy !== 1'b0 || bus.out_data !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset rdy=%b v=%b busy=%b d=%h want 1/0/0/0",
               bus.in_ready, bus.out_valid, bus.busy, bus.out_data);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.in_data   = 'x;
    bus.out_ready = 1'b0;
    rst_n         = 1'b1;
  endtask

  task automatic test_directed();
    xfer(4'b1011, 2'd2, 1'b0, 0);
    xfer(4'b0011, 2'd1, 1'b1, 0);
    xfer(4'b0101, 2'd0, 1'b1, 0);
    xfer(4'b1001, 2'd3, 1'b1, 0);
  endtask

  task automatic test_backpressure();
    xfer(4'b1100, 2'd3, 1'b0, 5);
    xfer(4'b0110, 2'd0, 1'b0, 5);
  endtask

  task automatic test_reset_mid_rot();
    int seen;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 4'b1101;
    bus.in_amt   = 2'd3;
    bus.in_dir   = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = 'x;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
        bus.busy !== 1'b0 || bus.out_data !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_reset rdy=%b v=%b busy=%b d=%h want 1/0/0/0",
               bus.in_ready, bus.out_valid, bus.busy, bus.out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) seen++;
    end
    n_chk++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL mid_reset_ghost cycles_active=%0d want=0", seen);
    end
  endtask

  task automatic test_exhaustive();
    int enc;
    for (int w = 0; w < 16; w++)
      for (int a = 0; a < 4; a++)
        for (int dir = 0; dir < 2; dir++) begin
          enc = (dir == 0) ? rotl(w, a) : rotr(w, a);
          xfer(4'(enc), 2'(a), dir[0], 0);
        end
  endtask

  task automatic test_back_to_back_random();
    for (int i = 0; i < 40; i++)
      xfer(4'($urandom), 2'($urandom), 1'($urandom),
           int'($urandom_range(0, 2)));
  endtask

  initial begin
    n_chk         = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_amt    = '0;
    bus.in_dir    = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_rot();
    test_exhaustive();
    test_back_to_back_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
